// File: rtl/lift_ctrl_n.sv
// lift_ctrl_n: N-floor elevator controller, SCAN order, travel/door timers.
// Ports: clk, rst_n (sync, active-low), req_valid/req_floor (call intake),
//        floor/dout/door_open/arrive (car status), done, pending, req_err.
module lift_ctrl_n #(
    parameter int FLOORS     = 8,
    parameter int FLOOR_W    = 3,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [FLOOR_W-1:0] req_floor,
    output logic [FLOOR_W-1:0] floor,
    output logic [1:0]         dout,
    output logic               door_open,
    output logic               arrive,
    output logic               done,
    output logic [FLOORS-1:0]  pending,
    output logic               req_err
);

    localparam int TW = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DW = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    localparam logic [TW-1:0] T_LOAD = TW'(TRAVEL_CYC - 1);
    localparam logic [DW-1:0] D_LOAD = DW'(DOOR_CYC - 1);

    localparam logic [FLOOR_W:0]  FLOORS_W = (FLOOR_W + 1)'(FLOORS);
    localparam logic [FLOORS-1:0] ONE      = FLOORS'(1);

    localparam logic [1:0] D_UP   = 2'b00;
    localparam logic [1:0] D_DOWN = 2'b01;
    localparam logic [1:0] D_STAY = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR
    } state_t;

    state_t            state, state_n;
    logic              dir_up, dir_n;
    logic [FLOOR_W-1:0] floor_n, floor_arr;
    logic [TW-1:0]     travel_cnt, travel_n;
    logic [DW-1:0]     door_cnt, door_n;
    logic [FLOORS-1:0] set_mask, clr_mask, req_mask, merged;
    logic              req_ok, arrive_n;
    logic              calls_above, calls_below, hit, beyond;

    // Bit for floor f, floors strictly below f, floors strictly above f.
    function automatic logic [FLOORS-1:0] at_m(input logic [FLOOR_W-1:0] f);
        return ONE << f;
    endfunction

    function automatic logic [FLOORS-1:0] below_m(input logic [FLOOR_W-1:0] f);
        return (ONE << f) - ONE;
    endfunction

    function automatic logic [FLOORS-1:0] above_m(input logic [FLOOR_W-1:0] f);
        return ~((ONE << f) | ((ONE << f) - ONE));
    endfunction

    assign req_ok   = req_valid && ({1'b0, req_floor} < FLOORS_W);
    assign req_mask = req_ok ? at_m(req_floor) : '0;

    assign calls_above = |(pending & above_m(floor));
    assign calls_below = |(pending & below_m(floor));

    // Arrival decisions see this edge's request so a call for the floor
    // being reached is absorbed by the stop instead of lingering.
    assign floor_arr = dir_up ? floor + FLOOR_W'(1) : floor - FLOOR_W'(1);
    assign merged    = pending | req_mask;
    assign hit       = |(merged & at_m(floor_arr));
    assign beyond    = dir_up ? |(merged & above_m(floor_arr))
                              : |(merged & below_m(floor_arr));

    assign done = (state == S_IDLE) && (pending == '0);

    always_comb begin
        state_n  = state;
        dir_n    = dir_up;
        floor_n  = floor;
        travel_n = travel_cnt;
        door_n   = door_cnt;
        arrive_n = 1'b0;
        set_mask = req_mask;
        clr_mask = '0;
        unique case (state)
            S_IDLE: begin
                if (pending != '0) begin
                    if (|(pending & at_m(floor))) begin
                        clr_mask = at_m(floor);
                        state_n  = S_DOOR;
                        door_n   = D_LOAD;
                    end else begin
                        // Keep heading up while calls remain above.
                        dir_n    = calls_above && (dir_up || !calls_below);
                        state_n  = S_MOVE;
                        travel_n = T_LOAD;
                    end
                end
            end
            S_MOVE: begin
                if (travel_cnt == '0) begin
                    floor_n  = floor_arr;
                    arrive_n = 1'b1;
                    if (hit) begin
                        clr_mask = at_m(floor_arr);
                        state_n  = S_DOOR;
                        door_n   = D_LOAD;
                    end else if (beyond) begin
                        travel_n = T_LOAD;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    travel_n = travel_cnt - TW'(1);
                end
            end
            S_DOOR: begin
                if (req_ok && (req_floor == floor)) begin
                    // Call for the open floor just holds the door.
                    set_mask = '0;
                    door_n   = D_LOAD;
                end else if (door_cnt == '0) begin
                    state_n = S_IDLE;
                end else begin
                    door_n = door_cnt - DW'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dir_up     <= 1'b1;
            floor      <= '0;
            pending    <= '0;
            travel_cnt <= '0;
            door_cnt   <= '0;
            dout       <= D_STAY;
            door_open  <= 1'b0;
            arrive     <= 1'b0;
            req_err    <= 1'b0;
        end else begin
            state      <= state_n;
            dir_up     <= dir_n;
            floor      <= floor_n;
            pending    <= (pending | set_mask) & ~clr_mask;
            travel_cnt <= travel_n;
            door_cnt   <= door_n;
            dout       <= (state_n == S_MOVE) ? (dir_n ? D_UP : D_DOWN)
                                              : D_STAY;
            door_open  <= (state_n == S_DOOR);
            arrive     <= arrive_n;
            req_err    <= req_valid && !req_ok;
        end
    end

    floor_range_a: assert property (
        @(posedge clk) disable iff (!rst_n) ({1'b0, floor} < FLOORS_W)
    );

endmodule

// File: tb/tb_lift_ctrl_n.sv
// tb_lift_ctrl_n: directed + random stimulus against a behavioural model.
// Two instances: 8 floors (FLOOR_W=4) and 2 floors (TRAVEL_CYC=1).
module tb_lift_ctrl_n;

    localparam int M_IDLE = 0;
    localparam int M_MOVE = 1;
    localparam int M_DOOR = 2;

    typedef struct {
        int        fl;
        bit        up;
        int        mode;
        int        tl;
        int        dl;
        bit [15:0] pend;
        bit        arr;
        bit        err;
    } mdl_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, v2;
    logic [3:0] f1;
    logic [0:0] f2;
    logic [3:0] floor1;
    logic [0:0] floor2;
    logic [1:0] dout1, dout2;
    logic       door1, door2, arr1, arr2, done1, done2, err1, err2;
    logic [7:0] pend1;
    logic [1:0] pend2;

    int   n_vec = 0;
    int   n_bad = 0;
    mdl_t m1, m2;
    int   door_q[$];
    bit   door_prev = 1'b0;
    int   door_cyc = 0;

    always #5 clk = ~clk;

    lift_ctrl_n #(
        .FLOORS(8), .FLOOR_W(4), .TRAVEL_CYC(4), .DOOR_CYC(3)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_floor(f1),
        .floor(floor1), .dout(dout1), .door_open(door1), .arrive(arr1),
        .done(done1), .pending(pend1), .req_err(err1)
    );

    lift_ctrl_n #(
        .FLOORS(2), .FLOOR_W(1), .TRAVEL_CYC(1), .DOOR_CYC(2)
    ) u_dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_floor(f2),
        .floor(floor2), .dout(dout2), .door_open(door2), .arrive(arr2),
        .done(done2), .pending(pend2), .req_err(err2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    // Cycle-level behaviour: idle picks a call, move steps a floor every
    // tc cycles, door stays open dc cycles (restarted by a same-floor call).
    function automatic mdl_t mstep(mdl_t m, bit rn, bit v, int rf,
                                   int nf, int tc, int dc);
        mdl_t      n;
        bit [15:0] rb;
        bit [15:0] abv;
        bit [15:0] blw;
        n = m;
        n.arr = 1'b0;
        n.err = 1'b0;
        if (!rn) begin
            n.fl = 0; n.up = 1'b1; n.mode = M_IDLE;
            n.tl = 0; n.dl = 0; n.pend = '0;
            return n;
        end
        rb = (v && rf < nf) ? (16'd1 << rf) : 16'd0;
        n.err = v && (rf >= nf);
        case (m.mode)
            M_IDLE: begin
                n.pend = m.pend | rb;
                if (m.pend != 0) begin
                    if (m.pend[m.fl]) begin
                        n.pend[m.fl] = 1'b0;
                        n.mode = M_DOOR;
                        n.dl = dc;
                    end else begin
                        abv = m.pend >> (m.fl + 1);
                        blw = m.pend & ((16'd1 << m.fl) - 16'd1);
                        n.up = (abv != 0) && (m.up || blw == 0);
                        n.mode = M_MOVE;
                        n.tl = tc;
                    end
                end
            end
            M_MOVE: begin
                n.tl = m.tl - 1;
                n.pend = m.pend | rb;
                if (n.tl == 0) begin
                    n.fl = m.up ? m.fl + 1 : m.fl - 1;
                    n.arr = 1'b1;
                    abv = n.pend >> (n.fl + 1);
                    blw = n.pend & ((16'd1 << n.fl) - 16'd1);
                    if (n.pend[n.fl]) begin
                        n.pend[n.fl] = 1'b0;
                        n.mode = M_DOOR;
                        n.dl = dc;
                    end else if (m.up ? abv != 0 : blw != 0) begin
                        n.tl = tc;
                    end else begin
                        n.mode = M_IDLE;
                    end
                end
            end
            default: begin
                if (v && rf == m.fl) begin
                    n.dl = dc;
                end else begin
                    n.pend = m.pend | rb;
                    n.dl = m.dl - 1;
                    if (n.dl == 0) n.mode = M_IDLE;
                end
            end
        endcase
        return n;
    endfunction

    function automatic int exp_dout(mdl_t m);
        if (m.mode == M_MOVE) return m.up ? 0 : 1;
        return 2;
    endfunction

    task automatic step(input bit rn, input bit a_v, input int a_f,
                        input bit b_v, input int b_f);
        rst_n = rn;
        v1 = a_v;
        f1 = 4'(a_f);
        v2 = b_v;
        f2 = 1'(b_f);
        @(posedge clk);
        m1 = mstep(m1, rn, a_v, a_f, 8, 4, 3);
        m2 = mstep(m2, rn, b_v, b_f, 2, 1, 2);
        #1;
        chk("u1_floor", 32'(floor1), 32'(m1.fl));
        chk("u1_dout", 32'(dout1), 32'(exp_dout(m1)));
        chk("u1_door", 32'(door1), 32'(m1.mode == M_DOOR));
        chk("u1_arrive", 32'(arr1), 32'(m1.arr));
        chk("u1_done", 32'(done1), 32'(m1.mode == M_IDLE && m1.pend == 0));
        chk("u1_err", 32'(err1), 32'(m1.err));
        chk("u1_pend", 32'(pend1), 32'(m1.pend));
        chk("u2_floor", 32'(floor2), 32'(m2.fl));
        chk("u2_dout", 32'(dout2), 32'(exp_dout(m2)));
        chk("u2_door", 32'(door2), 32'(m2.mode == M_DOOR));
        chk("u2_arrive", 32'(arr2), 32'(m2.arr));
        chk("u2_done", 32'(done2), 32'(m2.mode == M_IDLE && m2.pend == 0));
        chk("u2_err", 32'(err2), 32'(m2.err));
        chk("u2_pend", 32'(pend2), 32'(m2.pend));
        if (door1 && !door_prev) door_q.push_back(int'(floor1));
        if (door1) door_cyc++;
        door_prev = door1;
    endtask

    task automatic wait_done(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, 0);
            if (done1) return;
        end
        chk("wait_done_timeout", 32'(done1), 32'd1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 0, 1'b0, 0);
        step(1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        v1 = 1'b0; f1 = '0; v2 = 1'b0; f2 = '0;
        m1 = mstep(m1, 1'b0, 1'b0, 0, 8, 4, 3);
        m2 = mstep(m2, 1'b0, 1'b0, 0, 2, 1, 2);

        do_reset();
        chk("rst_floor", 32'(floor1), 32'd0);
        chk("rst_dout", 32'(dout1), 32'd2);
        chk("rst_done", 32'(done1), 32'd1);
        chk("rst_pend", 32'(pend1), 32'd0);

        // Single call to floor 5 from floor 0.
        for (int e = 0; e <= 25; e++) begin
            step(1'b1, e == 0, 5, 1'b0, 0);
            if (e == 1) chk("s1_up_e1", 32'(dout1), 32'd0);
            if (e == 4) chk("s1_floor_e4", 32'(floor1), 32'd0);
            if (e == 5) chk("s1_floor_e5", 32'(floor1), 32'd1);
            if (e == 5) chk("s1_arr_e5", 32'(arr1), 32'd1);
            if (e == 6) chk("s1_arr_e6", 32'(arr1), 32'd0);
            if (e == 17) chk("s1_floor_e17", 32'(floor1), 32'd4);
            if (e == 21) chk("s1_floor_e21", 32'(floor1), 32'd5);
            if (e == 21) chk("s1_door_e21", 32'(door1), 32'd1);
            if (e == 23) chk("s1_door_e23", 32'(door1), 32'd1);
            if (e == 24) chk("s1_door_e24", 32'(door1), 32'd0);
            if (e == 24) chk("s1_done_e24", 32'(done1), 32'd1);
            if (e == 24) chk("s1_stay_e24", 32'(dout1), 32'd2);
        end

        // At 4 heading up: calls 6 and 2 -> 6 first, then 2.
        do_reset();
        step(1'b1, 1'b1, 4, 1'b0, 0);
        wait_done(100);
        chk("s2_at4", 32'(floor1), 32'd4);
        door_q.delete();
        step(1'b1, 1'b1, 6, 1'b0, 0);
        step(1'b1, 1'b1, 2, 1'b0, 0);
        chk("s2_pend", 32'(pend1), 32'h44);
        wait_done(200);
        chk("s2_nstops", 32'(door_q.size()), 32'd2);
        if (door_q.size() == 2) begin
            chk("s2_first", 32'(door_q[0]), 32'd6);
            chk("s2_second", 32'(door_q[1]), 32'd2);
        end
        chk("s2_final", 32'(floor1), 32'd2);

        // Idle at 3: same-floor call, then a second one holds the door.
        do_reset();
        step(1'b1, 1'b1, 3, 1'b0, 0);
        wait_done(100);
        door_q.delete();
        door_cyc = 0;
        step(1'b1, 1'b1, 3, 1'b0, 0);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        chk("s3_door", 32'(door1), 32'd1);
        step(1'b1, 1'b1, 3, 1'b0, 0);
        wait_done(50);
        chk("s3_door_cyc", 32'(door_cyc), 32'd4);
        chk("s3_nomove", 32'(floor1), 32'd3);

        // Out-of-range call, then repeated calls to 5 while moving.
        step(1'b1, 1'b1, 9, 1'b0, 0);
        chk("s4_err", 32'(err1), 32'd1);
        chk("s4_pend", 32'(pend1), 32'd0);
        chk("s4_done", 32'(done1), 32'd1);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        chk("s4_err_pulse", 32'(err1), 32'd0);
        door_q.delete();
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 5, 1'b0, 0);
        chk("s4_single", 32'(pend1), 32'h20);
        wait_done(100);
        chk("s4_nstops", 32'(door_q.size()), 32'd1);

        // Reset between floors 2 and 3 while moving up.
        do_reset();
        step(1'b1, 1'b1, 5, 1'b0, 0);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 1'b0, 0);
        chk("s5_mid", 32'(floor1), 32'd2);
        step(1'b0, 1'b1, 6, 1'b0, 0);
        chk("s5_floor", 32'(floor1), 32'd0);
        chk("s5_pend", 32'(pend1), 32'd0);
        chk("s5_dout", 32'(dout1), 32'd2);
        chk("s5_door", 32'(door1), 32'd0);
        chk("s5_done", 32'(done1), 32'd1);

        // Two-floor car, alternating calls.
        step(1'b1, 1'b0, 0, 1'b1, 1);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        chk("s6_move", 32'(dout2), 32'd0);
        step(1'b1, 1'b0, 0, 1'b0, 0);
        chk("s6_floor1", 32'(floor2), 32'd1);
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 0, (i % 4) == 0, (i / 4) % 2);
        end

        // Random traffic on both cars.
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 399) != 0,
                 $urandom_range(0, 5) == 0, int'($urandom_range(0, 9)),
                 $urandom_range(0, 3) == 0, int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lift_ctrl_n.md
# lift_ctrl_n

Parametrised N-floor elevator controller. It is the successor to the fixed 4-floor lift FSM. It accepts floor requests through a valid/ready-free request port and merges them into a pending-call bitmask. Requests are served in SCAN (collective) order, with a per-floor travel timer and a door-dwell timer. It sits between the request arbiter/queue and the motor/door drivers, and keeps the existing UP/DOWN/STAY output encoding.

## Interface
- FLOORS, 8, number of floors (2..16); floors numbered 0..FLOORS-1
- FLOOR_W, 3, floor index width; must satisfy 2^FLOOR_W >= FLOORS
- TRAVEL_CYC, 4, cycles to move one floor (>=1)
- DOOR_CYC, 3, cycles the door stays open (>=1)

- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request strobe, sampled every edge
- req_floor  in  FLOOR_W  requested floor
- floor  out  FLOOR_W  current car floor (registered)
- dout  out  2  motion: 00 UP, 01 DOWN, 10 STAY (registered)
- door_open  out  1  door open (registered)
- arrive  out  1  one-cycle pulse on each floor change
- done  out  1  high when state is IDLE and pending==0
- pending  out  FLOORS  outstanding call bitmask
- req_err  out  1  one-cycle pulse when req_floor >= FLOORS is presented with req_valid

## Operation
- Reset values: state IDLE, floor 0, dir UP, pending 0, dout STAY, door_open 0, arrive 0, req_err 0, both counters 0, done 1.
- Request intake:
  - An edge with req_valid=1 and req_floor<FLOORS sets pending[req_floor].
  - Duplicate requests merge.
  - An out-of-range request pulses req_err and changes nothing.
  - Exceptions: a request for the current floor while in DOOR reloads the door counter to DOOR_CYC-1 and does not set pending.
  - A request for the current floor on the same edge the car arrives there is absorbed by that arrival.
- IDLE (dout STAY, door_open 0):
  - If pending==0, stay.
  - Else if pending[floor], clear it and go to DOOR.
  - Else pick a direction. UP if calls exist above and (dir==UP or no calls below). DOWN otherwise.
  - Set dir, go to MOVE, load travel_cnt=TRAVEL_CYC-1.
- MOVE (dout=dir):
  - travel_cnt decrements each edge.
  - On the edge where travel_cnt==0: floor steps by ±1 and arrive pulses.
  - On that same edge, the next state uses the new floor value. If pending[new floor], clear it and go to DOOR. Otherwise, if calls remain beyond in dir, reload travel_cnt and stay in MOVE. Otherwise go to IDLE.
- DOOR (dout STAY, door_open 1):
  - Enter with door_cnt=DOOR_CYC-1 and decrement each edge.
  - When door_cnt==0, go to IDLE.
  - IDLE re-evaluates with the dir preference preserved.
- floor never leaves 0..FLOORS-1. The direction logic guarantees this; an assertion on it is required.
- done is combinational from registered state and pending.

## Timing
- A request sampled at edge E is visible on pending after E.
- The IDLE decision occurs at edge E+1 (state→MOVE or DOOR).
- From MOVE entry at edge M, the car reaches floor+k at edge M+k·TRAVEL_CYC.
- Arrival at the target and DOOR entry happen on the same edge.
- door_open is high for exactly DOOR_CYC cycles when not extended. IDLE follows at the next edge.
- Request to the current floor while IDLE: DOOR at E+1 with no motion.
- Reset asserted in any state returns all outputs to reset values on the next edge. Pending calls are discarded.

## Test plan
- FLOORS=8, TRAVEL_CYC=4, DOOR_CYC=3. Reset, req 5 at edge 0 → MOVE at edge 1, dout UP; floor=1,2,…,5 at edges 5,9,13,17,21 with arrive pulses; door_open edges 21–23; IDLE/done at edge 24, dout STAY.
- Car at 4 with dir UP, requests 6 and 2 in the same idle window → serves 6 first (UP), door, then DOWN to 2; pending bits clear on each arrival.
- Car idle at 3, req 3 → no motion, door_open for 3 cycles. A second req 3 during DOOR → door held 3 more cycles from that edge.
- req_floor=9 (FLOOR_W=4, FLOORS=8) → req_err pulse, pending unchanged, state unchanged. Repeated req 5 while moving → single pending bit, single stop.
- Assert rst_n=0 mid-MOVE between floors 2 and 3 → next edge floor=0, pending=0, dout STAY, door_open=0, done=1.
- FLOORS=2, TRAVEL_CYC=1: alternate reqs 1/0 → floor toggles one edge after MOVE entry, never exceeds 1.
